// File: rtl/calc_pkg.sv
// Shared types and helpers for the MiniCalculator sequencing controller.
package calc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOper = 2'd1,
        StExec = 2'd2,
        StShow = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OpAdd = 2'd0,
        OpSub = 2'd1,
        OpMul = 2'd2,
        OpDiv = 2'd3
    } op_e;

    // Key vector layout fed to the edge detector: {clr, eq, op[3:0]}
    localparam int unsigned KeyW   = 6;
    localparam int unsigned KeyClr = 5;
    localparam int unsigned KeyEq  = 4;

    // Priority encode the operator keys: bit3 (add) wins over bit2 over bit1 over bit0
    function automatic op_e op_encode(input logic [3:0] btn);
        op_e op;
        if (btn[3]) begin
            op = OpAdd;
        end else if (btn[2]) begin
            op = OpSub;
        end else if (btn[1]) begin
            op = OpMul;
        end else begin
            op = OpDiv;
        end
        return op;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// N-bit rising-edge detector. History resets to all-ones so a key held
// through reset does not produce a spurious event on release of reset.
module btn_edge #(
    parameter int unsigned N = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] btn_i,
    output logic [N-1:0] rise_o
);

    logic [N-1:0] hist_q;

    // Previous-cycle key levels
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hist_q <= '1;
        end else begin
            hist_q <= btn_i;
        end
    end

    assign rise_o = btn_i & ~hist_q;

endmodule

// File: rtl/calc_ctrl.sv
// Sequencing controller: captures operands/operator from keys and switches,
// runs one start/done transaction on the ALU and holds the result for display.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [3:0]         op_btn_i,
    input  logic               eq_btn_i,
    input  logic               clr_btn_i,
    input  logic [WIDTH-1:0]   sw_val_i,
    output logic               alu_start_o,
    output logic [1:0]         alu_op_o,
    output logic [WIDTH-1:0]   alu_a_o,
    output logic [WIDTH-1:0]   alu_b_o,
    input  logic               alu_done_i,
    input  logic [2*WIDTH-1:0] alu_result_i,
    input  logic               alu_err_i,
    output logic [2*WIDTH-1:0] disp_val_o,
    output logic               disp_err_o,
    output logic               busy_o
);

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Count value during the last EXEC cycle before the timeout fires
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [KeyW-1:0] key_rise;
    logic [3:0]      op_rise;
    logic            eq_rise;
    logic            clr_rise;
    logic            op_any;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] disp_q, disp_d;
    logic               err_q, err_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               pend_q, pend_d;

    logic               do_clr;
    logic               done_ok;
    logic               clr_pend;

    btn_edge #(
        .N (KeyW)
    ) u_btn_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .btn_i  ({clr_btn_i, eq_btn_i, op_btn_i}),
        .rise_o (key_rise)
    );

    assign op_rise  = key_rise[3:0];
    assign eq_rise  = key_rise[KeyEq];
    assign clr_rise = key_rise[KeyClr];
    assign op_any   = |op_rise;

    // The ALU may not complete in the cycle it is being started
    assign done_ok  = alu_done_i && !start_q;
    assign clr_pend = pend_q || clr_rise;

    // Next-state logic for the FSM, operand registers, display and timeout counter
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        disp_d  = disp_q;
        err_d   = err_q;
        start_d = 1'b0;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        do_clr  = 1'b0;

        unique case (state_q)
            StIdle: begin
                disp_d = {{WIDTH{1'b0}}, sw_val_i};
                if (clr_rise) begin
                    do_clr = 1'b1;
                end else if (op_any) begin
                    a_d     = sw_val_i;
                    op_d    = op_encode(op_rise);
                    state_d = StOper;
                end
            end

            StOper: begin
                disp_d = {{WIDTH{1'b0}}, sw_val_i};
                if (clr_rise) begin
                    do_clr = 1'b1;
                end else if (op_any) begin
                    op_d = op_encode(op_rise);
                end else if (eq_rise) begin
                    b_d     = sw_val_i;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StExec;
                end
            end

            StExec: begin
                cnt_d = cnt_q + CntW'(1);
                if (clr_rise) begin
                    pend_d = 1'b1;
                end
                // A completion beats a timeout landing in the same cycle
                if (done_ok) begin
                    if (clr_pend) begin
                        do_clr = 1'b1;
                    end else begin
                        disp_d  = alu_result_i;
                        err_d   = alu_err_i;
                        state_d = StShow;
                    end
                end else if (cnt_q == CntLast) begin
                    if (clr_pend) begin
                        do_clr = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StShow;
                    end
                end
            end

            StShow: begin
                if (clr_rise) begin
                    do_clr = 1'b1;
                end else if (!err_q) begin
                    if (op_any) begin
                        a_d     = disp_q[WIDTH-1:0];
                        op_d    = op_encode(op_rise);
                        state_d = StOper;
                    end else if (eq_rise) begin
                        // Repeat the last operation using the result as operand A
                        a_d     = disp_q[WIDTH-1:0];
                        start_d = 1'b1;
                        cnt_d   = '0;
                        state_d = StExec;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (do_clr) begin
            state_d = StIdle;
            op_d    = OpAdd;
            a_d     = '0;
            b_d     = '0;
            disp_d  = '0;
            err_d   = 1'b0;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end

        busy_d = (state_d == StExec);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            op_q    <= OpAdd;
            a_q     <= '0;
            b_q     <= '0;
            disp_q  <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            disp_q  <= disp_d;
            err_q   <= err_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    assign alu_start_o = start_q;
    assign alu_op_o    = op_q;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign disp_val_o  = disp_q;
    assign disp_err_o  = err_q;
    assign busy_o      = busy_q;

    // Start is a single-cycle strobe that only accompanies entry into EXEC
    assert property (@(posedge clk_i) disable iff (!rst_ni) start_q |=> !start_q);
    assert property (@(posedge clk_i) disable iff (!rst_ni) start_q |-> busy_q);

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: table of operations plus hand-written
// sequences for chaining, errors, timeout, pending clear and reset.
module tb_calc_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned TO = 255;

    logic           clk;
    logic           rst_n;
    logic [3:0]     op_btn;
    logic           eq_btn;
    logic           clr_btn;
    logic [W-1:0]   sw_val;
    logic           alu_start;
    logic [1:0]     alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic           alu_done;
    logic [2*W-1:0] alu_result;
    logic           alu_err;
    logic [2*W-1:0] disp_val;
    logic           disp_err;
    logic           busy;

    calc_ctrl #(
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .op_btn_i     (op_btn),
        .eq_btn_i     (eq_btn),
        .clr_btn_i    (clr_btn),
        .sw_val_i     (sw_val),
        .alu_start_o  (alu_start),
        .alu_op_o     (alu_op),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_done_i   (alu_done),
        .alu_result_i (alu_result),
        .alu_err_i    (alu_err),
        .disp_val_o   (disp_val),
        .disp_err_o   (disp_err),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } txn_t;

    typedef struct {
        logic [3:0]   pat;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
    } vec_t;

    txn_t exp_q[$];
    txn_t obs_q[$];
    vec_t vecs[7];

    int checks = 0;
    int errors = 0;
    int dbl_start = 0;
    logic start_prev = 1'b0;

    // Record every start pulse the DUT issues, sampled on the falling edge
    always @(negedge clk) begin
        if (alu_start) begin
            obs_q.push_back({alu_op, alu_a, alu_b});
            if (start_prev) dbl_start <= dbl_start + 1;
        end
        start_prev <= alu_start;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic [1:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b);
        txn_t t;
        t.op = op;
        t.a  = a;
        t.b  = b;
        return t;
    endfunction

    // Reference ALU: {err, result}
    function automatic logic [2*W:0] alu_ref(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [2*W-1:0] r;
        logic           e;
        e = 1'b0;
        case (op)
            2'd0: r = (2*W)'(a) + (2*W)'(b);
            2'd1: r = (2*W)'(a) - (2*W)'(b);
            2'd2: r = (2*W)'(a) * (2*W)'(b);
            default: begin
                if (b == '0) begin
                    r = '0;
                    e = 1'b1;
                end else begin
                    r = (2*W)'(a / b);
                end
            end
        endcase
        return {e, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_op(input logic [3:0] pat);
        op_btn = pat;
        tick();
        op_btn = 4'b0000;
        tick();
    endtask

    // Ends in the cycle where alu_start is expected high
    task automatic press_eq();
        eq_btn = 1'b1;
        tick();
        eq_btn = 1'b0;
    endtask

    task automatic press_clr();
        clr_btn = 1'b1;
        tick();
        clr_btn = 1'b0;
        tick();
    endtask

    // Ends just after the edge that samples alu_done
    task automatic alu_respond(input int lat, input logic [2*W-1:0] res, input logic err);
        repeat (lat) tick();
        alu_done   = 1'b1;
        alu_result = res;
        alu_err    = err;
        tick();
        alu_done   = 1'b0;
        alu_result = '0;
        alu_err    = 1'b0;
    endtask

    // Compare observed start pulses against the expected queue
    task automatic drain(input string name);
        txn_t o;
        txn_t e;
        check({name, "_start_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({name, "_alu_op"}, o.op, e.op);
            check({name, "_alu_a"}, o.a, e.a);
            check({name, "_alu_b"}, o.b, e.b);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [2*W:0] r;

        vecs[0] = '{pat: 4'b1000, a: 8'd5,   b: 8'd3,   op: 2'd0};
        vecs[1] = '{pat: 4'b0111, a: 8'd9,   b: 8'd4,   op: 2'd1};
        vecs[2] = '{pat: 4'b0011, a: 8'd7,   b: 8'd6,   op: 2'd2};
        vecs[3] = '{pat: 4'b0001, a: 8'd200, b: 8'd0,   op: 2'd3};
        vecs[4] = '{pat: 4'b1111, a: 8'd255, b: 8'd255, op: 2'd0};
        vecs[5] = '{pat: 4'b0101, a: 8'd100, b: 8'd7,   op: 2'd1};
        vecs[6] = '{pat: 4'b0001, a: 8'd200, b: 8'd7,   op: 2'd3};

        // Reset with the add key held throughout
        rst_n = 1'b0; op_btn = 4'b1000; eq_btn = 1'b0; clr_btn = 1'b0;
        sw_val = 8'd77; alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
        tick(); tick();
        check("rst_alu_start", alu_start, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_disp_val", disp_val, 0);
        check("rst_disp_err", disp_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(); tick();
        check("held_key_no_capture", alu_a, 0);
        check("idle_disp_follows_sw", disp_val, 77);
        eq_btn = 1'b1; tick(); eq_btn = 1'b0; tick(); tick();
        check("held_key_busy", busy, 0);
        drain("held_key");
        op_btn = 4'b0000;
        sw_val = 8'd42;
        tick();
        check("idle_disp_follows_sw2", disp_val, 42);

        // Operation table
        for (int i = 0; i < 7; i++) begin
            press_clr();
            sw_val = vecs[i].a;
            press_op(vecs[i].pat);
            sw_val = vecs[i].b;
            exp_q.push_back(mk(vecs[i].op, vecs[i].a, vecs[i].b));
            press_eq();
            check("vec_busy_exec", busy, 1);
            r = alu_ref(vecs[i].op, vecs[i].a, vecs[i].b);
            alu_respond(3, r[2*W-1:0], r[2*W]);
            check("vec_disp_val", disp_val, r[2*W-1:0]);
            check("vec_disp_err", disp_err, r[2*W]);
            check("vec_busy_show", busy, 0);
            drain("vec");
        end

        // Basic add, then chain a multiply and repeat it
        press_clr();
        sw_val = 8'd5; press_op(4'b1000);
        sw_val = 8'd3; exp_q.push_back(mk(2'd0, 8'd5, 8'd3));
        press_eq();
        alu_respond(4, 16'd8, 1'b0);
        check("add_disp_val", disp_val, 8);
        check("add_disp_err", disp_err, 0);
        sw_val = 8'd2; press_op(4'b0010);
        check("chain_oper_disp_sw", disp_val, 2);
        exp_q.push_back(mk(2'd2, 8'd8, 8'd2));
        press_eq();
        alu_respond(2, 16'd16, 1'b0);
        check("chain_disp_val", disp_val, 16);
        exp_q.push_back(mk(2'd2, 8'd16, 8'd2));
        press_eq();
        alu_respond(2, 16'd32, 1'b0);
        check("repeat_disp_val", disp_val, 32);
        drain("chain");

        // clr and eq edges together in OPER: clear wins, no start
        press_clr();
        sw_val = 8'd10; press_op(4'b1000);
        sw_val = 8'd11;
        clr_btn = 1'b1; eq_btn = 1'b1;
        tick();
        clr_btn = 1'b0; eq_btn = 1'b0;
        check("clr_eq_disp_val", disp_val, 0);
        check("clr_eq_alu_a", alu_a, 0);
        tick(); tick();
        check("clr_eq_busy", busy, 0);
        drain("clr_eq");

        // Divide by zero: error locks out op/eq until clear
        sw_val = 8'd9; press_op(4'b0001);
        sw_val = 8'd0; exp_q.push_back(mk(2'd3, 8'd9, 8'd0));
        press_eq();
        alu_respond(2, 16'd0, 1'b1);
        check("div0_disp_err", disp_err, 1);
        sw_val = 8'd3; press_op(4'b1000);
        eq_btn = 1'b1; tick(); eq_btn = 1'b0; tick(); tick();
        check("div0_locked_err", disp_err, 1);
        check("div0_locked_busy", busy, 0);
        drain("div0");
        clr_btn = 1'b1; tick(); clr_btn = 1'b0;
        check("div0_clr_disp_val", disp_val, 0);
        check("div0_clr_disp_err", disp_err, 0);
        tick();
        check("div0_clr_idle", disp_val, 3);

        // Done in the start cycle is ignored
        sw_val = 8'd6; press_op(4'b0100);
        sw_val = 8'd2; exp_q.push_back(mk(2'd1, 8'd6, 8'd2));
        press_eq();
        alu_done = 1'b1; alu_result = 16'd99;
        tick();
        alu_done = 1'b0; alu_result = '0;
        check("early_done_busy", busy, 1);
        alu_respond(2, 16'd4, 1'b0);
        check("early_done_disp_val", disp_val, 4);
        drain("early_done");

        // Timeout after exactly TO EXEC cycles
        press_clr();
        sw_val = 8'd1; press_op(4'b1000);
        sw_val = 8'd1; exp_q.push_back(mk(2'd0, 8'd1, 8'd1));
        press_eq();
        repeat (TO - 1) tick();
        check("timeout_pre_busy", busy, 1);
        check("timeout_pre_err", disp_err, 0);
        tick();
        check("timeout_err", disp_err, 1);
        check("timeout_busy", busy, 0);
        drain("timeout");

        // Clear during EXEC is held until done; result discarded
        press_clr();
        sw_val = 8'd4; press_op(4'b1000);
        sw_val = 8'd4; exp_q.push_back(mk(2'd0, 8'd4, 8'd4));
        press_eq();
        tick();
        clr_btn = 1'b1; tick(); clr_btn = 1'b0;
        check("pend_clr_busy", busy, 1);
        alu_respond(1, 16'd8, 1'b0);
        check("pend_clr_disp_val", disp_val, 0);
        check("pend_clr_disp_err", disp_err, 0);
        check("pend_clr_busy_after", busy, 0);
        tick();
        check("pend_clr_idle", disp_val, 4);
        drain("pend_clr");

        // Reset mid-EXEC, then a late done
        sw_val = 8'd3; press_op(4'b0100);
        sw_val = 8'd4; exp_q.push_back(mk(2'd1, 8'd3, 8'd4));
        press_eq();
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_alu_start", alu_start, 0);
        check("mid_rst_alu_op", alu_op, 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_b", alu_b, 0);
        check("mid_rst_disp_val", disp_val, 0);
        check("mid_rst_busy", busy, 0);
        rst_n = 1'b1;
        alu_done = 1'b1; alu_result = 16'h1234;
        tick();
        alu_done = 1'b0; alu_result = '0;
        check("late_done_disp_val", disp_val, 4);
        check("late_done_disp_err", disp_err, 0);
        check("late_done_busy", busy, 0);
        tick();
        drain("mid_rst");

        check("start_single_cycle", dbl_start, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the MiniCalculator datapath. It takes the sampled operator buttons plus equals/clear keys, captures operand A, the operator and operand B from the switches, and issues one start/done transaction to the multi-cycle ALU. It then holds the result or error for the display stage and supports chained and repeated operations. It sits between the button sampler and the ALU/display logic.

## Interface
- WIDTH, 8, operand width in bits
- TIMEOUT, 255, max cycles to wait for alu_done before forcing an error
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- op_btn  in  4  sampled operator keys; bit3 add, bit2 sub, bit1 mul, bit0 div; level
- eq_btn  in  1  equals key, level
- clr_btn  in  1  clear key, level
- sw_val  in  WIDTH  operand from switches
- alu_start  out  1  one-cycle start pulse to ALU
- alu_op  out  2  00 add, 01 sub, 10 mul, 11 div
- alu_a, alu_b  out  WIDTH  operands, stable from alu_start until done or timeout
- alu_done  in  1  one-cycle completion pulse
- alu_result  in  2*WIDTH  result, valid with alu_done
- alu_err  in  1  error (e.g. divide by zero), valid with alu_done
- disp_val  out  2*WIDTH  value to display, registered
- disp_err  out  1  error indicator, registered
- busy  out  1  high in EXEC

## Operation
- Key events are rising edges: key high now, low in the previous cycle.
- Edge registers reset to all-ones, so a key held through reset produces no event.
- Several op edges in one cycle: priority bit3 > bit2 > bit1 > bit0.
- A clr edge outranks every other event in the same cycle.
- States: IDLE, OPER, EXEC, SHOW. All outputs are registered.
- IDLE
  - disp_val follows sw_val, zero-extended.
  - op edge: A <= sw_val, latch the encoded op, go to OPER.
  - eq edge: ignored.
- OPER
  - disp_val follows sw_val.
  - op edge: replace the op; A unchanged.
  - eq edge: B <= sw_val, alu_start = 1 for the next cycle, go to EXEC.
- EXEC
  - busy = 1. Op and eq edges are ignored.
  - alu_done is ignored in the alu_start cycle.
  - alu_done: disp_val <= alu_result, disp_err <= alu_err, go to SHOW.
  - clr edge: sets a pending-clear flag. On the next alu_done or timeout, go to IDLE, discard the result and set disp_val to 0.
  - Timeout: the counter reaches TIMEOUT with no done. Set disp_err = 1, go to SHOW.
- SHOW
  - op edge with disp_err = 0: A <= disp_val[WIDTH-1:0] (truncated), latch the op, go to OPER.
  - eq edge with disp_err = 0: A <= disp_val[WIDTH-1:0], keep B and op, pulse alu_start, go to EXEC (repeat last op).
  - With disp_err = 1, only clr is honoured.
- clr edge in IDLE, OPER or SHOW: A, B, op, disp_val and disp_err go to 0; state goes to IDLE.

## Timing
- Reset (rst_n low at a clock edge) sets:
  - state IDLE; alu_start 0; alu_op 00; alu_a 0; alu_b 0
  - disp_val 0; disp_err 0; busy 0; timeout counter 0; pending-clear 0
- Reset mid-EXEC abandons the transaction. A later alu_done in IDLE is ignored.
- Key edge present at clock edge N: state and latched values update at N; alu_start is high in the cycle after N.
- alu_done sampled high at edge M: disp_val and disp_err are valid after M; state is SHOW after M.
- Timeout counter:
  - cleared when alu_start is issued, then increments each EXEC cycle.
  - timeout fires at count == TIMEOUT.
  - a done and the timeout in the same cycle: done wins.
- alu_start is never high for more than one cycle and is never asserted outside EXEC entry.

## Structure
- calc_pkg holds:
  - the state enum (IDLE/OPER/EXEC/SHOW)
  - the op enum (ADD=0, SUB=1, MUL=2, DIV=3)
  - function op_encode(4-bit one-hot with priority) returning 2 bits
- Sub-module btn_edge (parameter N): N-bit rising-edge detector with reset-to-ones history, used once for {clr, eq, op[3:0]}.
- The FSM, timeout counter and operand registers live in calc_ctrl.

## Test plan
- **Basic add:** sw=5, add edge; sw=3, eq edge; ALU returns done with result 8 after 4 cycles -> one alu_start pulse with alu_op=00, a=5, b=3; disp_val=8, disp_err=0, state SHOW.
- **Priority:** op_btn=4'b0111 edge -> alu_op=01 (sub). clr and eq edges in the same cycle in OPER -> IDLE, no alu_start.
- **Chain and repeat:** after the result 8, a mul edge with sw=2 then eq -> a=8, b=2, op 10. A further eq in SHOW -> a=16, b=2, repeats mul.
- **Divide error:** div with b=0 and ALU returns alu_err=1 -> disp_err=1. Op and eq edges are then ignored; clr -> disp_val=0, disp_err=0, IDLE.
- **Timeout and pending clear:**
  - No alu_done -> disp_err=1 after exactly TIMEOUT EXEC cycles.
  - clr during EXEC, then done -> IDLE, disp_val=0, result discarded.
- **Reset behaviour:** rst_n low mid-EXEC -> all outputs at reset values; a late alu_done is ignored. A key held high through reset produces no event.
